// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame buffer.
package uart_rx_pkg;

  localparam int RX_MIN_DATA_BITS = 5;
  localparam int RX_MAX_DATA_BITS = 8;

  // One received frame as stored in the receive FIFO.
  typedef struct packed {
    logic                        frame_err;
    logic                        parity_err;
    logic [RX_MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Map a configured data-bit count to the count actually used.
  // Illegal values fall back to the widest frame.
  function automatic logic [3:0] rx_eff_data_bits(input logic [3:0] cfg);
    if (cfg >= 4'(RX_MIN_DATA_BITS) && cfg <= 4'(RX_MAX_DATA_BITS)) begin
      return cfg;
    end
    return 4'(RX_MAX_DATA_BITS);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is refused.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = rx_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               push_ok;
  logic               pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write. When full with a pop, wr_ptr equals rd_ptr and the
  // head slot is reused after the current head has been consumed.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness comes from level, and leaving it out keeps this a plain RAM.
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Receive frame assembler: shifts in data bits LSB-first on the rx FSM's
// strobes, checks parity and stop bits, and queues each frame with its
// error flags in a FIFO drained through a valid/ready port.
module uart_rx_frame_buffer
  import uart_rx_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic                       shift_bits,
  input  logic                       done,
  input  logic [3:0]                 cfg_data_bits,
  input  logic                       cfg_parity_en,
  input  logic                       cfg_parity_odd,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int                IDX_W   = $clog2(DATA_W + 2);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DATA_W + 1);

  typedef struct packed {
    logic              frame_err;
    logic              parity_err;
    logic [DATA_W-1:0] data;
  } frame_entry_t;

  // Frame assembly state.
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              par_bit_q, par_bit_d;
  // Configuration held for the frame in progress.
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              overrun_q, overrun_d;

  // Effective configuration: live inputs before the first bit, latched after.
  logic [3:0]        nbits;
  logic              par_en;
  logic              par_odd;
  logic [IDX_W-1:0]  need_bits;
  logic [DATA_W-1:0] frame_data;
  logic              exp_par;
  frame_entry_t      new_entry;

  frame_entry_t      head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_now;
  logic              dropped;

  // Frame assembly and end-of-frame checks.
  always_comb begin
    nbits   = (idx_q == '0) ? rx_eff_data_bits(cfg_data_bits) : nbits_q;
    par_en  = (idx_q == '0) ? cfg_parity_en  : par_en_q;
    par_odd = (idx_q == '0) ? cfg_parity_odd : par_odd_q;

    need_bits  = IDX_W'(nbits) + IDX_W'(par_en);
    frame_data = sr_q >> (DATA_W - int'(nbits));
    exp_par    = (^frame_data) ^ par_odd;

    new_entry.data       = frame_data;
    new_entry.parity_err = par_en & (par_bit_q != exp_par);
    new_entry.frame_err  = ~rx | (idx_q < need_bits);

    idx_d     = idx_q;
    sr_d      = sr_q;
    par_bit_d = par_bit_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;

    if (done) begin
      // A coincident shift strobe is ignored; the frame closes here.
      idx_d     = '0;
      sr_d      = '0;
      par_bit_d = 1'b0;
    end else if (shift_bits) begin
      if (idx_q == '0) begin
        nbits_d   = nbits;
        par_en_d  = par_en;
        par_odd_d = par_odd;
      end
      if (idx_q < IDX_W'(nbits)) begin
        sr_d = {rx, sr_q[DATA_W-1:1]};
      end else if (idx_q == IDX_W'(nbits) && par_en) begin
        par_bit_d = rx;
      end
      if (idx_q != IDX_MAX) idx_d = idx_q + IDX_W'(1);
    end
  end

  // Sticky overrun: a frame that finds the FIFO full with no pop is lost.
  always_comb begin
    pop_now   = rd_ready & ~fifo_empty;
    dropped   = done & fifo_full & ~pop_now;
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (dropped)     overrun_d = 1'b1;
  end

  // Assembler, configuration and overrun registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      sr_q      <= '0;
      par_bit_q <= 1'b0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      par_bit_q <= par_bit_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (frame_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .pop   (rd_ready),
    .din   (new_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Head outputs are forced to zero while empty so stale storage never shows.
  assign rd_valid      = ~fifo_empty;
  assign rd_data       = fifo_empty ? '0 : head.data;
  assign rd_parity_err = ~fifo_empty & head.parity_err;
  assign rd_frame_err  = ~fifo_empty & head.frame_err;
  assign overrun       = overrun_q;

endmodule

// File: doc/uart_rx_frame_buffer.md
Name: uart_rx_frame_buffer

Overview:
Downstream stage of the UART receive FSM. It samples the serial line on the FSM's per-bit strobes and assembles data bits LSB-first, then checks the parity and stop bits. Each completed frame is pushed with its error flags into a small receive FIFO, which the CSR/host side drains through a valid/ready read port. Overruns are tracked with a sticky flag.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
DATA_W, 8, maximum data bits per frame (shift register width)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rx  input  1  synchronized serial line (same signal the rx FSM sees)
shift_bits  input  1  one-cycle strobe from rx FSM: sample rx as next data/parity bit
done  input  1  one-cycle strobe from rx FSM: sample rx as stop bit, frame complete
cfg_data_bits  input  4  data bits per frame, legal 5..8
cfg_parity_en  input  1  frame carries a parity bit
cfg_parity_odd  input  1  1 = odd parity, 0 = even parity
rd_ready  input  1  consumer accepts head entry
rd_valid  output  1  FIFO non-empty
rd_data  output  DATA_W  head data, right-justified, upper bits zero
rd_parity_err  output  1  head entry parity error
rd_frame_err  output  1  head entry framing error (stop bit 0 or short frame)
level  output  $clog2(DEPTH+1)  current FIFO occupancy
overrun  output  1  sticky: a frame was dropped because the FIFO was full
overrun_clr  input  1  clears overrun

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0, FIFO empty, level=0, bit counter=0, shift register=0, overrun=0.
- Config latch: cfg_* are captured on the first shift_bits of a frame (bit counter==0) and held until done. cfg_data_bits values outside 5..8 are treated as 8.
- Bit counter idx (0..DATA_W+1) increments on every shift_bits:
  - idx < nbits: rx shifts into sr as sr <= {rx, sr[DATA_W-1:1]}.
  - idx == nbits with parity enabled: rx is stored in par_bit.
  - Any later shift_bits: ignored; idx saturates.
- On done:
  - data = sr >> (DATA_W - nbits).
  - exp_par = ^data XOR cfg_parity_odd.
  - parity_err = parity_en & (par_bit != exp_par).
  - frame_err = ~rx | (idx < nbits + parity_en).
  - The entry {frame_err, parity_err, data} is pushed, then idx, sr and par_bit are cleared.
- shift_bits and done in the same cycle: done wins; the shift is ignored.
- Latency: done in cycle N gives rd_valid=1 and the entry visible at the head in cycle N+1.
- Pop: occurs when rd_valid & rd_ready. The head outputs update the next cycle. With rd_valid=0, rd_ready has no effect.
- Push when full:
  - Without a simultaneous pop: the frame is dropped, overrun is set to 1, and the FIFO is unchanged.
  - With a pop in the same cycle: the push is accepted and level is unchanged.
- Push and pop when empty: cannot coincide, since rd_valid=0. The entry appears next cycle.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers: log2(DEPTH) bits, wrap naturally. full/empty are derived from level.
- overrun: set by a dropped push, cleared by overrun_clr. Set and clear in the same cycle: set wins.
- Reset mid-frame or with a non-empty FIFO: everything is discarded; the next frame starts at idx 0.

Decomposition:
- UART_rx_pkg gets:
  - typedef rx_entry_t {frame_err, parity_err, data[DATA_W-1:0]}.
  - Constants RX_MIN_DATA_BITS=5 and RX_MAX_DATA_BITS=8.
- Sub-module uart_rx_fifo: parameterized DEPTH × rx_entry_t.
  - Ports: push, pop, din, dout, full, empty, level.
  - Sync active-high reset; implements the full-with-pop accept rule.
- The top level holds the frame assembler, checks and overrun flag.

Test Plan:
- 8N1, drive 0xA5 LSB-first with 8 shift_bits, then done with rx=1 -> next cycle rd_valid=1, rd_data=0xA5, both error flags 0, level=1.
- 7E1, data 0x35 (four 1s) with parity bit 1 -> rd_parity_err=1. Repeat with parity bit 0 -> rd_parity_err=0, rd_data=0x35 (bit 7 zero).
- 5O1, data 0x1F with parity bit 0, stop rx=0 -> rd_data=0x1F, rd_parity_err=0, rd_frame_err=1.
- Fill the FIFO with 8 frames holding rd_ready=0, push a 9th -> level=8, overrun=1, head still frame 1. Pulse overrun_clr -> overrun=0.
- Full FIFO, done and a pop in the same cycle -> level stays 8 and the new frame becomes the tail. Drain all -> data order matches send order, rd_valid drops after the last.
- Assert rst after 4 shift_bits of a frame, then send a full 8N1 frame 0x3C -> only 0x3C is received, error flags 0.
